// File: rtl/egress_buf.sv
// Egress buffer behind one crossbar output: captures packets routed to this port
// into a first-word-fall-through FIFO and drains them over valid/ready.
module egress_buf #(
  parameter int PKT_W   = 10,
  parameter int DEPTH   = 4,
  parameter int PORT_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         in_pkt,
  output logic [PKT_W-1:0]         out_pkt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               misr_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             arrive, hit, misr, push, pop, drop;

  assign arrive = in_pkt[PKT_W-1];
  assign hit    = arrive && (in_pkt[PKT_W-2 -: 2] == 2'(PORT_ID));
  assign misr   = arrive && !hit;
  assign pop    = out_valid && out_ready;
  // A full FIFO still accepts an arrival when the head leaves on the same edge.
  assign push   = hit && (!full || pop);
  assign drop   = hit && full && !pop;

  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign out_pkt   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      misr_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (misr && misr_cnt != 8'hFF) misr_cnt <= misr_cnt + 8'd1;
    end
  end

  // Storage needs no reset; out_pkt is masked while empty.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= in_pkt;
  end
endmodule
